ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit replacing the free-running dual PC register pair in the single-cycle core. It owns the fetch PC, issues one outstanding word request at a time to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO toward the decoder. A redirect from execute (jal/branch/trap) flushes the FIFO and squashes any in-flight response.

---
 rtl/ifu_prefetch.sv | 174 +++++++++++++++++
 tb/tb_ifu_prefetch.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Brief    : Instruction fetch unit. Owns the fetch PC, keeps at most one word
//            request outstanding and buffers {pc, inst, err} in a DEPTH-entry
//            FIFO toward decode. Optional macro IFU_PERF_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
    parameter int              XLEN   = 64,
    parameter int              INST_W = 32,
    parameter logic [XLEN-1:0] PC_RST = 64'h8000_0000,
    parameter int              DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [XLEN-1:0]   req_addr,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_data,
    input  logic              resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_err,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   issued_pc;
    logic [XLEN-1:0]   redirect_aligned;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   fifo_pc   [DEPTH];
    logic [INST_W-1:0] fifo_inst [DEPTH];
    logic [DEPTH-1:0]  fifo_err;
    logic              has_space;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              redirect_lsb_unused;

    assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Requests only issue with a free slot, so a returning response can always be pushed.
    assign has_space  = (count < DEPTH_C);
    assign req_valid  = !rst && (state == S_IDLE) && has_space && !redirect_valid;
    assign req_addr   = fetch_pc;
    assign req_fire   = req_valid && req_ready;

    assign push       = (state == S_WAIT) && resp_valid && !redirect_valid;
    assign inst_valid = (count != '0);
    assign pop        = inst_ready && inst_valid && !redirect_valid;

    assign inst       = fifo_inst[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];
    assign inst_err   = inst_valid && fifo_err[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (redirect_valid) begin
                    state_nxt = S_IDLE;
                end else if (req_fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    state_nxt = S_IDLE;
                end else if (redirect_valid) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                // The squashed response retires the outstanding request even
                // when another redirect lands in the same cycle.
                if (resp_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            fetch_pc  <= PC_RST;
            issued_pc <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
            end else if (req_fire) begin
                fetch_pc  <= fetch_pc + XLEN'(4);
                issued_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_err <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr           <= wr_ptr + AW'(1);
                fifo_err[wr_ptr] <= resp_err;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Payload storage needs no reset: every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= issued_pc;
            fifo_inst[wr_ptr] <= resp_data;
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (inst_ready && !inst_valid && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// Testbench for ifu_prefetch: directed scenarios plus a randomized run against
// a queue-based fetch-stream model. Build with IFU_PERF_EN to cover counters.
module tb_ifu_prefetch;

    localparam logic [63:0] PC_RST = 64'h8000_0000;
    localparam int          DEPTH  = 4;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        err;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model controls
    int          mem_lat   = 0;
    bit          mem_rand  = 1'b0;
    logic [31:0] data_mask = '0;
    logic [63:0] err_addr  = '1;
    bit          pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_data = '0;
    logic        pend_err  = 1'b0;

    ifu_prefetch #(
        .XLEN   (64),
        .INST_W (32),
        .PC_RST (PC_RST),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: answers each accepted request after pend_cnt idle cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend       = 1'b0;
                resp_valid = 1'b0;
            end else if (pend && pend_cnt == 0) begin
                resp_valid = 1'b1;
                resp_data  = pend_data;
                resp_err   = pend_err;
                pend       = 1'b0;
            end else begin
                resp_valid = 1'b0;
                resp_data  = $urandom;
                resp_err   = 1'b0;
                if (pend) pend_cnt--;
            end
            #2;
            if (rst) begin
                pend = 1'b0;
            end else if (req_valid && req_ready) begin
                pend      = 1'b1;
                pend_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                pend_data = req_addr[31:0] ^ data_mask;
                pend_err  = mem_rand ? ($urandom_range(0, 4) == 0) : (req_addr == err_addr);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        req_ready      = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid got %b exp 0", req_valid); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %b exp 0", inst_valid); else n_pass++;
        n_checks++; if (inst_err !== 1'b0) $display("FAIL rst_inst_err got %b exp 0", inst_err); else n_pass++;
`ifdef IFU_PERF_EN
        n_checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0)
            $display("FAIL rst_perf got %h/%h exp 0/0", perf_fetched, perf_stall); else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (req_valid !== 1'b1) $display("FAIL rst_first_req got %b exp 1", req_valid); else n_pass++;
        n_checks++; if (req_addr !== PC_RST) $display("FAIL rst_first_addr got %h exp %h", req_addr, PC_RST); else n_pass++;
    endtask

    task automatic test_stream();
        int pops = 0;
        int last = 0;
        mem_lat = 0;
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (inst_valid) begin
                n_checks++; if (inst_pc !== PC_RST + 64'(4 * pops))
                    $display("FAIL stream_pc got %h exp %h", inst_pc, PC_RST + 64'(4 * pops)); else n_pass++;
                n_checks++; if (inst !== 32'h8000_0000 + 32'(4 * pops))
                    $display("FAIL stream_inst got %h exp %h", inst, 32'h8000_0000 + 32'(4 * pops)); else n_pass++;
                if (pops > 0) begin
                    n_checks++; if (c - last != 2) $display("FAIL stream_gap got %0d exp 2", c - last); else n_pass++;
                end
                last = c;
                pops++;
            end
        end
        n_checks++; if (pops != 7) $display("FAIL stream_count got %0d exp 7", pops); else n_pass++;
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        mem_lat = 0;
        do_reset();
        req_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_valid && req_ready) acc++;
        end
        n_checks++; if (acc != DEPTH) $display("FAIL full_requests got %0d exp %0d", acc, DEPTH); else n_pass++;
        n_checks++; if (req_valid !== 1'b0) $display("FAIL full_req_valid got %b exp 0", req_valid); else n_pass++;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== PC_RST)
            $display("FAIL full_head got v=%b pc=%h exp v=1 pc=%h", inst_valid, inst_pc, PC_RST); else n_pass++;
        @(negedge clk);
        inst_ready = 1'b1;
        #1;
        acc = (req_valid && req_ready) ? 1 : 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            inst_ready = 1'b0;
            #1;
            if (req_valid && req_ready) acc++;
        end
        n_checks++; if (acc != 1) $display("FAIL full_refill got %0d exp 1", acc); else n_pass++;
        n_checks++; if (inst_pc !== PC_RST + 64'd4) $display("FAIL full_head2 got %h exp %h", inst_pc, PC_RST + 64'd4); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit seen = 1'b0;
        mem_lat   = 2;
        data_mask = 32'hDEAD_BEEF ^ 32'h8000_0000;
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        #1;
        n_checks++; if (req_valid !== 1'b1 || req_addr !== PC_RST)
            $display("FAIL rdw_issue got v=%b a=%h exp v=1 a=%h", req_valid, req_addr, PC_RST); else n_pass++;
        @(negedge clk);
        mem_lat        = 0;
        data_mask      = '0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        #1;
        n_checks++; if (req_valid !== 1'b0) $display("FAIL rdw_req_during got %b exp 0", req_valid); else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (req_valid !== 1'b0) $display("FAIL rdw_drop_req got %b exp 0", req_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL rdw_resp_cycle got resp=%b req=%b iv=%b exp 1/0/0", resp_valid, req_valid, inst_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rdw_discard got %b exp 0", inst_valid); else n_pass++;
        n_checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100)
            $display("FAIL rdw_new_req got v=%b a=%h exp v=1 a=%h", req_valid, req_addr, 64'h8000_0100); else n_pass++;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                seen = 1'b1;
                n_checks++; if (inst_pc !== 64'h8000_0100 || inst !== 32'h8000_0100)
                    $display("FAIL rdw_first got pc=%h inst=%h exp pc=%h inst=%h", inst_pc, inst, 64'h8000_0100, 32'h8000_0100); else n_pass++;
            end
        end
        n_checks++; if (!seen) $display("FAIL rdw_timeout got no inst exp inst within 8 cycles"); else n_pass++;
    endtask

    task automatic test_redirect_resp();
        bit seen = 1'b0;
        mem_lat = 0;
        do_reset();
        req_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        inst_ready     = 1'b1;
        #1;
        n_checks++; if (resp_valid !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b1)
            $display("FAIL rdr_setup got resp=%b req=%b iv=%b exp 1/0/1", resp_valid, req_valid, inst_valid); else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rdr_no_push got %b exp 0", inst_valid); else n_pass++;
        n_checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100)
            $display("FAIL rdr_new_req got v=%b a=%h exp v=1 a=%h", req_valid, req_addr, 64'h8000_0100); else n_pass++;
        inst_ready = 1'b1;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                seen = 1'b1;
                n_checks++; if (inst_pc !== 64'h8000_0100)
                    $display("FAIL rdr_first got %h exp %h", inst_pc, 64'h8000_0100); else n_pass++;
            end
        end
        n_checks++; if (!seen) $display("FAIL rdr_timeout got no inst exp inst within 8 cycles"); else n_pass++;
    endtask

    task automatic test_err();
        int pops = 0;
        mem_lat  = 0;
        err_addr = PC_RST + 64'd4;
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 16 && pops < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (inst_valid) begin
                n_checks++; if (inst_pc !== PC_RST + 64'(4 * pops) || inst_err !== (pops == 1))
                    $display("FAIL err_entry%0d got pc=%h err=%b exp pc=%h err=%b", pops, inst_pc, inst_err,
                             PC_RST + 64'(4 * pops), (pops == 1)); else n_pass++;
                pops++;
            end
        end
        n_checks++; if (pops != 4) $display("FAIL err_continue got %0d exp 4", pops); else n_pass++;
        err_addr = '1;
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        bit seen = 1'b0;
        mem_lat = 0;
        do_reset();
        req_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 4) mem_lat = 8;
            end
        end
        @(negedge clk);
        #1;
        n_checks++; if (inst_valid !== 1'b1 || req_valid !== 1'b0)
            $display("FAIL rmid_setup got iv=%b rv=%b exp 1/0", inst_valid, req_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (inst_valid !== 1'b0 || req_valid !== 1'b0 || inst_err !== 1'b0)
            $display("FAIL rmid_clear got iv=%b rv=%b err=%b exp 0/0/0", inst_valid, req_valid, inst_err); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        mem_lat = 0;
        inst_ready = 1'b1;
        #1;
        n_checks++; if (req_valid !== 1'b1 || req_addr !== PC_RST)
            $display("FAIL rmid_restart got v=%b a=%h exp v=1 a=%h", req_valid, req_addr, PC_RST); else n_pass++;
`ifdef IFU_PERF_EN
        n_checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0)
            $display("FAIL rmid_perf got %h/%h exp 0/0", perf_fetched, perf_stall); else n_pass++;
`endif
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                seen = 1'b1;
                n_checks++; if (inst_pc !== PC_RST) $display("FAIL rmid_first got %h exp %h", inst_pc, PC_RST); else n_pass++;
            end
        end
        n_checks++; if (!seen) $display("FAIL rmid_timeout got no inst exp inst within 8 cycles"); else n_pass++;
    endtask

    // Model: the expected fetch stream is a sequential PC walk restarted by
    // redirects; delivered entries are a queue of non-squashed responses.
    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic [63:0] exp_pc;
        logic [63:0] issued;
        bit          outst;
        bit          squashed;
        bit          exp_rv;
        int unsigned fetched;
        int unsigned stalls;
        exp_pc   = PC_RST;
        issued   = '0;
        outst    = 1'b0;
        squashed = 1'b0;
        fetched  = 0;
        stalls   = 0;
        mem_rand  = 1'b1;
        data_mask = 32'hA5A5_0F0F;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c > 0) @(negedge clk);
            req_ready      = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = PC_RST + 64'($urandom_range(0, 1023));
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                2:       redirect_pc = {$urandom, $urandom};
                default: redirect_pc = PC_RST;
            endcase
            #1;
            exp_rv = !outst && (q.size() < DEPTH) && !redirect_valid;
            n_checks++; if (req_valid !== exp_rv)
                $display("FAIL rnd_req_valid cyc=%0d got %b exp %b", c, req_valid, exp_rv); else n_pass++;
            if (exp_rv) begin
                n_checks++; if (req_addr !== exp_pc)
                    $display("FAIL rnd_req_addr cyc=%0d got %h exp %h", c, req_addr, exp_pc); else n_pass++;
            end
            n_checks++; if (inst_valid !== (q.size() != 0))
                $display("FAIL rnd_inst_valid cyc=%0d got %b exp %b", c, inst_valid, (q.size() != 0)); else n_pass++;
            if (q.size() != 0) begin
                n_checks++; if (inst_pc !== q[0].pc || inst !== q[0].ins || inst_err !== q[0].err)
                    $display("FAIL rnd_head cyc=%0d got pc=%h inst=%h err=%b exp pc=%h inst=%h err=%b",
                             c, inst_pc, inst, inst_err, q[0].pc, q[0].ins, q[0].err); else n_pass++;
            end
`ifdef IFU_PERF_EN
            n_checks++; if (perf_fetched !== fetched || perf_stall !== stalls)
                $display("FAIL rnd_perf cyc=%0d got %0d/%0d exp %0d/%0d", c, perf_fetched, perf_stall, fetched, stalls); else n_pass++;
`endif
            if (inst_ready && q.size() == 0) stalls++;
            if (redirect_valid) begin
                q.delete();
                exp_pc = {redirect_pc[63:2], 2'b00};
                if (outst && resp_valid) begin
                    outst    = 1'b0;
                    squashed = 1'b0;
                end else if (outst) begin
                    squashed = 1'b1;
                end
            end else begin
                if (inst_ready && q.size() != 0) q.delete(0);
                if (outst && resp_valid) begin
                    if (!squashed) begin
                        e.pc  = issued;
                        e.ins = issued[31:0] ^ data_mask;
                        e.err = resp_err;
                        q.push_back(e);
                        fetched++;
                    end
                    outst    = 1'b0;
                    squashed = 1'b0;
                end
                if (exp_rv && req_ready) begin
                    outst    = 1'b1;
                    squashed = 1'b0;
                    issued   = exp_pc;
                    exp_pc   = exp_pc + 64'd4;
                end
            end
        end
        mem_rand  = 1'b0;
        data_mask = '0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fifo_full();
        test_redirect_wait();
        test_redirect_resp();
        test_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
